// File: rtl/frame_buffer_arbiter.sv
// Triple-buffer arbiter: hands DDR frame base addresses to a writer and a reader.
// Writer fills W, reader shows R, the spare S = 3-W-R carries the newest complete frame.
module frame_buffer_arbiter #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter logic [31:0] FRAME_BYTES = 32'h0009_6000
) (
   input  logic        clk_100Mhz,
   input  logic        rst,
   input  logic        wr_frame_start,
   input  logic        wr_frame_done,
   input  logic        rd_frame_start,
   output logic [31:0] wr_base_addr,
   output logic [31:0] rd_base_addr,
   output logic [1:0]  wr_buf_idx,
   output logic [1:0]  rd_buf_idx,
   output logic        rd_valid,
   output logic        wr_active,
   output logic [15:0] drop_cnt,
   output logic [15:0] repeat_cnt
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_n;
   logic [1:0]  r_w;
   logic [1:0]  r_r;
   logic        r_fresh;
   logic        r_rd_valid;
   logic        r_wr_active;
   logic [15:0] r_drop_cnt;
   logic [15:0] r_repeat_cnt;
   logic [31:0] r_wr_addr;
   logic [31:0] r_rd_addr;

   logic        w_done_acc;
   logic [1:0]  w_w_n;
   logic [1:0]  w_r_n;
   logic        w_fresh_n;
   logic        w_rd_valid_n;
   logic [15:0] w_drop_n;
   logic [15:0] w_repeat_n;

   function automatic logic [31:0] f_addr(input logic [1:0] idx);
      logic [31:0] v_idx;
      v_idx  = {30'd0, idx};
      f_addr = BASE_ADDR + v_idx * FRAME_BYTES;
   endfunction

   function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
      f_sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // W and R are always distinct values in 0..2, so the spare never wraps.
   function automatic logic [1:0] f_spare(input logic [1:0] w, input logic [1:0] r);
      f_spare = 2'd3 - w - r;
   endfunction

   assign w_done_acc = wr_frame_done && (r_state == ST_ACTIVE);

   always_comb begin
      w_state_n    = r_state;
      w_w_n        = r_w;
      w_r_n        = r_r;
      w_fresh_n    = r_fresh;
      w_rd_valid_n = r_rd_valid;
      w_drop_n     = r_drop_cnt;
      w_repeat_n   = r_repeat_cnt;

      case (r_state)
         ST_IDLE:   if (wr_frame_start) w_state_n = ST_ACTIVE;
         ST_ACTIVE: if (w_done_acc && !wr_frame_start) w_state_n = ST_IDLE;
         default:   w_state_n = ST_IDLE;
      endcase

      // Completed write is published first, so a simultaneous read picks it up.
      if (w_done_acc) begin
         w_w_n     = f_spare(r_w, r_r);
         w_fresh_n = 1'b1;
         if (r_fresh) w_drop_n = f_sat_inc(r_drop_cnt);
      end

      if (rd_frame_start) begin
         if (w_fresh_n) begin
            w_r_n        = f_spare(w_w_n, r_r);
            w_fresh_n    = 1'b0;
            w_rd_valid_n = 1'b1;
         end else if (r_rd_valid) begin
            w_repeat_n = f_sat_inc(r_repeat_cnt);
         end
      end
   end

   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_w          <= 2'd0;
         r_r          <= 2'd1;
         r_fresh      <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_wr_active  <= 1'b0;
         r_drop_cnt   <= 16'd0;
         r_repeat_cnt <= 16'd0;
         r_wr_addr    <= f_addr(2'd0);
         r_rd_addr    <= f_addr(2'd1);
      end else begin
         r_state      <= w_state_n;
         r_w          <= w_w_n;
         r_r          <= w_r_n;
         r_fresh      <= w_fresh_n;
         r_rd_valid   <= w_rd_valid_n;
         r_wr_active  <= (w_state_n == ST_ACTIVE);
         r_drop_cnt   <= w_drop_n;
         r_repeat_cnt <= w_repeat_n;
         r_wr_addr    <= f_addr(w_w_n);
         r_rd_addr    <= f_addr(w_r_n);
      end
   end

   assign wr_base_addr = r_wr_addr;
   assign rd_base_addr = r_rd_addr;
   assign wr_buf_idx   = r_w;
   assign rd_buf_idx   = r_r;
   assign rd_valid     = r_rd_valid;
   assign wr_active    = r_wr_active;
   assign drop_cnt     = r_drop_cnt;
   assign repeat_cnt   = r_repeat_cnt;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: reset, handoff, drop, repeat and collision cases.
module tb_frame_buffer_arbiter;

   logic        clk_100Mhz;
   logic        rst;
   logic        wr_frame_start;
   logic        wr_frame_done;
   logic        rd_frame_start;
   logic [31:0] wr_base_addr;
   logic [31:0] rd_base_addr;
   logic [1:0]  wr_buf_idx;
   logic [1:0]  rd_buf_idx;
   logic        rd_valid;
   logic        wr_active;
   logic [15:0] drop_cnt;
   logic [15:0] repeat_cnt;

   int checks;
   int failures;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h1009_6000;
   localparam logic [31:0] A2 = 32'h1012_C000;

   frame_buffer_arbiter dut (
      .clk_100Mhz    (clk_100Mhz),
      .rst           (rst),
      .wr_frame_start(wr_frame_start),
      .wr_frame_done (wr_frame_done),
      .rd_frame_start(rd_frame_start),
      .wr_base_addr  (wr_base_addr),
      .rd_base_addr  (rd_base_addr),
      .wr_buf_idx    (wr_buf_idx),
      .rd_buf_idx    (rd_buf_idx),
      .rd_valid      (rd_valid),
      .wr_active     (wr_active),
      .drop_cnt      (drop_cnt),
      .repeat_cnt    (repeat_cnt)
   );

   initial clk_100Mhz = 1'b0;
   always #5 clk_100Mhz = ~clk_100Mhz;

   // One clock with the given pulses held; outputs are sampled 1ns after the edge.
   task automatic step(input logic r, input logic s, input logic d, input logic rd);
      rst            = r;
      wr_frame_start = s;
      wr_frame_done  = d;
      rd_frame_start = rd;
      @(posedge clk_100Mhz);
      #1;
      rst            = 1'b0;
      wr_frame_start = 1'b0;
      wr_frame_done  = 1'b0;
      rd_frame_start = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0);
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL rst_wr_idx got=%0d exp=0", wr_buf_idx); end
      checks++; if (rd_buf_idx !== 2'd1) begin failures++; $display("FAIL rst_rd_idx got=%0d exp=1", rd_buf_idx); end
      checks++; if (wr_base_addr !== A0) begin failures++; $display("FAIL rst_wr_addr got=%h exp=%h", wr_base_addr, A0); end
      checks++; if (rd_base_addr !== A1) begin failures++; $display("FAIL rst_rd_addr got=%h exp=%h", rd_base_addr, A1); end
      checks++; if ({rd_valid, wr_active} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {rd_valid, wr_active}); end
      checks++; if ({drop_cnt, repeat_cnt} !== 32'd0) begin failures++; $display("FAIL rst_counts got=%h exp=0", {drop_cnt, repeat_cnt}); end
      step(0, 0, 0, 1);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL early_rd_valid got=%b exp=0", rd_valid); end
      checks++; if (rd_buf_idx !== 2'd1) begin failures++; $display("FAIL early_rd_idx got=%0d exp=1", rd_buf_idx); end
      checks++; if (repeat_cnt !== 16'd0) begin failures++; $display("FAIL early_repeat got=%0d exp=0", repeat_cnt); end
   endtask

   task automatic test_single_frame();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      checks++; if (wr_active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", wr_active); end
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL start_wr_idx got=%0d exp=0", wr_buf_idx); end
      step(0, 0, 1, 0);
      checks++; if (wr_buf_idx !== 2'd2) begin failures++; $display("FAIL done_wr_idx got=%0d exp=2", wr_buf_idx); end
      checks++; if (wr_base_addr !== A2) begin failures++; $display("FAIL done_wr_addr got=%h exp=%h", wr_base_addr, A2); end
      checks++; if (wr_active !== 1'b0) begin failures++; $display("FAIL done_active got=%b exp=0", wr_active); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL done_rd_valid got=%b exp=0", rd_valid); end
      step(0, 0, 0, 1);
      checks++; if (rd_buf_idx !== 2'd0) begin failures++; $display("FAIL read_rd_idx got=%0d exp=0", rd_buf_idx); end
      checks++; if (rd_base_addr !== A0) begin failures++; $display("FAIL read_rd_addr got=%h exp=%h", rd_base_addr, A0); end
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL read_rd_valid got=%b exp=1", rd_valid); end
      checks++; if (repeat_cnt !== 16'd0) begin failures++; $display("FAIL read_repeat got=%0d exp=0", repeat_cnt); end
   endtask

   task automatic test_drop();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL drop_first got=%0d exp=0", drop_cnt); end
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_second got=%0d exp=1", drop_cnt); end
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL drop_wr_idx got=%0d exp=0", wr_buf_idx); end
      checks++; if (wr_base_addr !== A0) begin failures++; $display("FAIL drop_wr_addr got=%h exp=%h", wr_base_addr, A0); end
      step(0, 0, 0, 1);
      checks++; if (rd_buf_idx !== 2'd2) begin failures++; $display("FAIL drop_rd_idx got=%0d exp=2", rd_buf_idx); end
      checks++; if (rd_base_addr !== A2) begin failures++; $display("FAIL drop_rd_addr got=%h exp=%h", rd_base_addr, A2); end
   endtask

   task automatic test_same_cycle();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 1);
      checks++; if (rd_buf_idx !== 2'd0) begin failures++; $display("FAIL coll_rd_idx got=%0d exp=0", rd_buf_idx); end
      checks++; if (wr_buf_idx !== 2'd2) begin failures++; $display("FAIL coll_wr_idx got=%0d exp=2", wr_buf_idx); end
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL coll_rd_valid got=%b exp=1", rd_valid); end
      checks++; if ({drop_cnt, repeat_cnt} !== 32'd0) begin failures++; $display("FAIL coll_counts got=%h exp=0", {drop_cnt, repeat_cnt}); end
      // Nothing fresh remains, so the next read must be a repeat.
      step(0, 0, 0, 1);
      checks++; if (repeat_cnt !== 16'd1) begin failures++; $display("FAIL coll_then_repeat got=%0d exp=1", repeat_cnt); end
   endtask

   task automatic test_repeat();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      checks++; if (repeat_cnt !== 16'd3) begin failures++; $display("FAIL rep_count got=%0d exp=3", repeat_cnt); end
      checks++; if (rd_buf_idx !== 2'd0) begin failures++; $display("FAIL rep_rd_idx got=%0d exp=0", rd_buf_idx); end
      step(0, 0, 1, 0);
      checks++; if (wr_buf_idx !== 2'd2) begin failures++; $display("FAIL idle_done_wr_idx got=%0d exp=2", wr_buf_idx); end
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL idle_done_drop got=%0d exp=0", drop_cnt); end
      checks++; if (wr_active !== 1'b0) begin failures++; $display("FAIL idle_done_active got=%b exp=0", wr_active); end
      step(0, 0, 0, 1);
      checks++; if (repeat_cnt !== 16'd4) begin failures++; $display("FAIL idle_done_nofresh got=%0d exp=4", repeat_cnt); end
   endtask

   task automatic test_back_to_back();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL restart_wr_idx got=%0d exp=0", wr_buf_idx); end
      checks++; if (wr_active !== 1'b1) begin failures++; $display("FAIL restart_active got=%b exp=1", wr_active); end
      step(0, 1, 1, 0);
      checks++; if (wr_buf_idx !== 2'd2) begin failures++; $display("FAIL b2b_wr_idx got=%0d exp=2", wr_buf_idx); end
      checks++; if (wr_active !== 1'b1) begin failures++; $display("FAIL b2b_active got=%b exp=1", wr_active); end
      step(0, 0, 1, 0);
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL b2b_second_wr_idx got=%0d exp=0", wr_buf_idx); end
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL b2b_drop got=%0d exp=1", drop_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      step(1, 0, 1, 1);
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL midrst_wr_idx got=%0d exp=0", wr_buf_idx); end
      checks++; if (rd_buf_idx !== 2'd1) begin failures++; $display("FAIL midrst_rd_idx got=%0d exp=1", rd_buf_idx); end
      checks++; if (wr_base_addr !== A0) begin failures++; $display("FAIL midrst_wr_addr got=%h exp=%h", wr_base_addr, A0); end
      checks++; if (rd_base_addr !== A1) begin failures++; $display("FAIL midrst_rd_addr got=%h exp=%h", rd_base_addr, A1); end
      checks++; if ({rd_valid, wr_active} !== 2'b00) begin failures++; $display("FAIL midrst_flags got=%b exp=00", {rd_valid, wr_active}); end
      checks++; if ({drop_cnt, repeat_cnt} !== 32'd0) begin failures++; $display("FAIL midrst_counts got=%h exp=0", {drop_cnt, repeat_cnt}); end
      // A done right after reset finds the writer idle and must be ignored.
      step(0, 0, 1, 0);
      checks++; if (wr_buf_idx !== 2'd0) begin failures++; $display("FAIL midrst_done_ignored got=%0d exp=0", wr_buf_idx); end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b0;
      wr_frame_start = 1'b0;
      wr_frame_done  = 1'b0;
      rd_frame_start = 1'b0;
      @(negedge clk_100Mhz);
      test_reset();
      test_single_frame();
      test_drop();
      test_same_cycle();
      test_repeat();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001: Parameter BASE_ADDR, default 32'h1000_0000, DDR byte address of buffer 0.
REQ-002: Parameter FRAME_BYTES, default 32'h0009_6000, byte stride between buffers (640x480x2).
REQ-003: clk_100Mhz  input  1  sole clock; all logic on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: wr_frame_start  input  1  one-cycle pulse: writer begins a frame; synchronous to clk_100Mhz.
REQ-006: wr_frame_done  input  1  one-cycle pulse: writer finished the last burst of a frame.
REQ-007: rd_frame_start  input  1  one-cycle pulse: reader begins a display frame (vsync_start_pulse, already synchronised).
REQ-008: wr_base_addr  output  32  frame base address for the writer.
REQ-009: rd_base_addr  output  32  frame base address for the reader.
REQ-010: wr_buf_idx / rd_buf_idx  output  2 each  buffer indices (0..2) owned by writer / reader.
REQ-011: rd_valid  output  1  high once at least one complete frame has been handed to the reader.
REQ-012: wr_active  output  1  writer FSM in ACTIVE.
REQ-013: drop_cnt / repeat_cnt  output  16 each  frames overwritten unread / display frames re-shown.

Function
REQ-014: Triple buffering SHALL be used: writer index W, reader index R, spare S = 3-W-R; W != R at all times.
REQ-015: Flag fresh SHALL mean S holds a complete frame newer than R.
REQ-016: Writer FSM SHALL have states IDLE and ACTIVE; wr_frame_start moves IDLE->ACTIVE; accepted wr_frame_done moves ACTIVE->IDLE.
REQ-017: wr_frame_start while ACTIVE SHALL restart the frame in the same W; no index change, no count.
REQ-018: wr_frame_done while IDLE SHALL be ignored.
REQ-019: Accepted done SHALL set W<=S, fresh<=1; if fresh was already 1, drop_cnt SHALL increment.
REQ-020: rd_frame_start with fresh=1 SHALL set R<=S, fresh<=0, rd_valid<=1.
REQ-021: rd_frame_start with fresh=0 and rd_valid=1 SHALL leave R unchanged and increment repeat_cnt.
REQ-022: rd_frame_start with fresh=0 and rd_valid=0 SHALL have no effect.
REQ-023: Accepted done and rd_frame_start in the same cycle: done applied first, then read; net R<=old W, W<=old S, fresh<=0, rd_valid<=1; drop_cnt increments iff old fresh=1; no repeat count.
REQ-024: wr_frame_start and wr_frame_done in the same cycle while ACTIVE SHALL be treated as done then start (state stays ACTIVE, new W).
REQ-025: All outputs SHALL be registered; index/address changes SHALL appear on the cycle after the triggering pulse (latency 1).
REQ-026: wr_base_addr = BASE_ADDR + wr_buf_idx*FRAME_BYTES, likewise rd_base_addr; 32-bit arithmetic, computed from next-state index so address and index change together.
REQ-027: drop_cnt and repeat_cnt SHALL saturate at 16'hFFFF.
REQ-028: Writer addresses SHALL NOT change while ACTIVE except via REQ-024.

Reset
REQ-029: On rst=1 at a clock edge: W=0, R=1, fresh=0, FSM=IDLE, rd_valid=0, wr_active=0, counters=0, wr_base_addr=BASE_ADDR, rd_base_addr=BASE_ADDR+FRAME_BYTES.
REQ-030: rst SHALL override all simultaneous pulses; reset mid-frame abandons the frame with no count.

Verification
REQ-031: Reset, then rd_frame_start -> rd_valid=0, rd_buf_idx=1, repeat_cnt=0.
REQ-032: start, done, then rd_frame_start -> after done wr_buf_idx=2, wr_base_addr=32'h1012_C000; after read rd_buf_idx=0, rd_base_addr=32'h1000_0000, rd_valid=1.
REQ-033: Two start/done pairs with no read -> drop_cnt=1, wr_buf_idx=0, fresh frame in buffer 2; next read gives rd_buf_idx=2.
REQ-034: Done and rd_frame_start in the same cycle from reset-plus-start -> rd_buf_idx=0, wr_buf_idx=2, drop_cnt=0, repeat_cnt=0.
REQ-035: After one consumed frame, three rd_frame_start with no done -> repeat_cnt=3, rd_buf_idx unchanged; done while IDLE -> no change.
REQ-036: Assert rst while ACTIVE with done pulse same cycle -> all values per REQ-029 next cycle.
